led_display_arbiter: RTL and testbench
======================================

// Module: led_display_arbiter
// PURPOSE
//  Shares the 8-bit board LED bank between N_REQ status requesters.
//  Each requester posts an 8-bit pattern with a valid/ready handshake.
//  The granted pattern is shown for a fixed hold time. With no grant active,
//  the block passes idle_pattern through; the free-running LFSR blinker drives it.
//  Sits between the status sources and the top-level led_output pins.
// PARAMETERS
//  N_REQ        4           number of requesters (2..8)
//  CNT_W        24          hold counter width
//  HOLD_CYCLES  10_000_000  cycles a granted pattern is displayed (>=1; 0 behaves as 1)
// PORTS
//  aclk          in   1        system clock
//  areset        in   1        synchronous reset, active-high
//  req_valid     in   N_REQ    requester i has a pattern pending
//  req_pattern   in   8*N_REQ  pattern of requester i, bits [8i+7:8i]
//  req_ready     out  N_REQ    one-cycle accept pulse, one-hot
//  idle_pattern  in   8        pattern shown when no grant is active
//  led_output    out  8        registered LED drive
//  grant         out  N_REQ    one-hot owner of the LEDs, 0 when idle
//  busy          out  1        1 while in SHOW
// BEHAVIOUR
//  Reset (areset=1 at a clock edge):
//   - led_output=0, req_ready=0, grant=0, busy=0.
//   - state=IDLE, rr pointer=0, so requester 0 has top priority.
//   - The hold counter is cleared.
//   - Reset mid-SHOW aborts the display at once. There is no ready for an aborted grant.
//  FSM, 2 states:
//   - IDLE:
//     - led_output<=idle_pattern (1-cycle latency).
//     - If any req_valid: pick winner w by round robin; go to SHOW.
//   - SHOW:
//     - led_output holds the latched pattern.
//     - Counter counts HOLD_CYCLES-1 down to 0.
//     - At 0 with any req_valid: re-arbitrate straight into a new SHOW (no idle gap).
//     - At 0 with no req_valid: go to IDLE.
//  Grant at edge t (req_valid[w]=1 sampled at t):
//   - req_pattern[w] is latched at t.
//   - From t+1: req_ready[w]=1 for exactly one cycle; grant=onehot(w); busy=1.
//   - led_output shows the latched pattern from t+1.
//   - It holds for exactly HOLD_CYCLES cycles, t+1..t+HOLD_CYCLES.
//  Handshake:
//   - A requester holds valid and pattern until it sees ready.
//   - Deasserting valid before ready withdraws the request: no grant, no ready.
//   - After ready, the requester may re-raise valid immediately. That is a new request.
//   - Pattern changes during SHOW are ignored; the latched value is shown.
//  Round robin:
//   - Search starts at (last winner+1) mod N_REQ.
//   - The last winner therefore has lowest priority at the next arbitration.
//   - The pointer advances only on a grant.
//  Simultaneous events:
//   - End of hold and new requests in the same cycle: the new requests are arbitrated.
//   - The finishing requester's new valid competes at lowest priority.
//  Widths:
//   - The counter saturates at 0; there is no wrap.
//   - HOLD_CYCLES is truncated to CNT_W bits.
// STRUCTURE
//  Package led_arb_pkg:
//   - LED_W=8.
//   - typedef enum {IDLE, SHOW} led_arb_state_t.
//  Sub-module rr_arbiter #(N):
//   - Inputs: req vector and pointer.
//   - Outputs: one-hot gnt and gnt_valid, combinational.
//   - The pointer register lives in the parent.
//  Parent contents: FSM, hold counter, pattern latch, output registers.
// TESTING (bench uses HOLD_CYCLES=4, N_REQ=4)
//  1. Reset held for 3 cycles with all req_valid=1:
//     - led_output=0, grant=0, req_ready=0 throughout.
//     - After release, idle_pattern=8'hA5 appears on led_output 1 cycle later.
//  2. req_valid[2]=1, pattern 8'h3C, sampled at t:
//     - req_ready=4'b0100 at t+1 only; grant=4'b0100 at t+1..t+4.
//     - led_output=8'h3C at t+1..t+4; idle_pattern at t+5.
//  3. All four req_valid=1 after reset:
//     - Grants 0,1,2,3 in order, 4 cycles each, back-to-back.
//     - busy stays 1 for 16 cycles.
//  4. req0 re-raises valid right after its ready while req1 is pending:
//     - req1 is served before req0 is served again.
//  5. areset pulses during the 2nd SHOW cycle of req3:
//     - Next cycle: led_output=0, grant=0.
//     - The next request from req0 and req3 together is granted to req0.
//  6. req_valid[1] high for 1 cycle only while req0 is showing:
//     - req_ready[1] is never asserted; the block returns to IDLE after req0's hold.

Source files
------------

// File: rtl/led_arb_pkg.sv
// Shared types and constants for the LED display arbiter.
package led_arb_pkg;

  localparam int LED_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } led_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first active request at or after ptr wins.
// The pointer register is owned by the caller so it only moves on a real grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic                 gnt_valid
);

  localparam int PW = $clog2(N);

  // Walk the requesters starting at ptr, wrapping modulo N, and keep the first hit.
  always_comb begin
    int idx;
    gnt       = '0;
    gnt_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!gnt_valid && req[PW'(idx)]) begin
        gnt[PW'(idx)] = 1'b1;
        gnt_valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_display_arbiter.sv
// Shares the board LED bank between N_REQ status requesters. A granted pattern is
// shown for HOLD_CYCLES cycles; with no owner the idle pattern is passed through.
module led_display_arbiter
  import led_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int CNT_W       = 24,
  parameter int HOLD_CYCLES = 10_000_000
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ-1:0][LED_W-1:0]  req_pattern,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [LED_W-1:0]             idle_pattern,
  output logic [LED_W-1:0]             led_output,
  output logic [N_REQ-1:0]             grant,
  output logic                         busy
);

  localparam int PW = $clog2(N_REQ);

  // Hold length is truncated to the counter width; zero is treated as one cycle.
  localparam logic [CNT_W-1:0] HOLD_T = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] RELOAD = (HOLD_T == '0) ? '0 : HOLD_T - CNT_W'(1);

  led_arb_state_t     state;
  logic [CNT_W-1:0]   cnt;
  logic [PW-1:0]      ptr;
  logic [N_REQ-1:0]   arb_gnt;
  logic               arb_vld;
  logic [PW-1:0]      win_idx;
  logic [PW-1:0]      ptr_nxt;
  logic [LED_W-1:0]   win_pat;
  logic               hold_done;
  logic               take;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .gnt       (arb_gnt),
    .gnt_valid (arb_vld)
  );

  // Encode the one-hot winner and mux out its pattern.
  always_comb begin
    win_idx = '0;
    win_pat = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) begin
        win_idx = PW'(i);
        win_pat = win_pat | req_pattern[i];
      end
    end
  end

  // Arbitration opens in IDLE or on the last SHOW cycle; the pointer lands just past the winner.
  always_comb begin
    hold_done = (state == IDLE) || (cnt == '0);
    take      = arb_vld && hold_done;
    ptr_nxt   = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + PW'(1);
  end

  // FSM with registered outputs; led_output doubles as the pattern latch during SHOW.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= '0;
      led_output <= '0;
      req_ready  <= '0;
      grant      <= '0;
      busy       <= 1'b0;
    end else begin
      req_ready <= '0;
      if (take) begin
        state      <= SHOW;
        led_output <= win_pat;
        grant      <= arb_gnt;
        req_ready  <= arb_gnt;
        busy       <= 1'b1;
        cnt        <= RELOAD;
        ptr        <= ptr_nxt;
      end else if (hold_done) begin
        state      <= IDLE;
        led_output <= idle_pattern;
        grant      <= '0;
        busy       <= 1'b0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_led_display_arbiter.sv
// Cycle table bench for led_display_arbiter (N_REQ=4, HOLD_CYCLES=4).
module tb_led_display_arbiter;

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] vld;
    logic [7:0] p2;
    logic [7:0] idle;
    logic [7:0] led;
    logic [3:0] gnt;
    logic [3:0] rdy;
    logic       busy;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] led;
    logic [3:0] gnt;
    logic [3:0] rdy;
    logic       busy;
  } exp_t;

  logic            aclk = 1'b0;
  logic            areset = 1'b1;
  logic [3:0]      req_valid = '0;
  logic [3:0][7:0] req_pattern;
  logic [3:0]      req_ready;
  logic [7:0]      idle_pattern = 8'hA5;
  logic [7:0]      led_output;
  logic [3:0]      grant;
  logic            busy;

  vec_t  vecs[$];
  exp_t  sb[$];
  int    n_vec = 0;
  int    n_bad = 0;
  string cur = "";
  logic [7:0] cur_p2 = 8'h3C;
  logic [7:0] cur_idle = 8'hA5;
  logic [7:0] pat [4];

  always #5 aclk = ~aclk;

  led_display_arbiter #(.N_REQ(4), .CNT_W(24), .HOLD_CYCLES(4)) dut (
    .aclk         (aclk),
    .areset       (areset),
    .req_valid    (req_valid),
    .req_pattern  (req_pattern),
    .req_ready    (req_ready),
    .idle_pattern (idle_pattern),
    .led_output   (led_output),
    .grant        (grant),
    .busy         (busy)
  );

  task automatic add(input logic rst, input logic [3:0] v, input logic [7:0] led,
                     input logic [3:0] g, input logic [3:0] r, input logic b);
    vec_t x;
    x.name = cur; x.rst = rst; x.vld = v; x.p2 = cur_p2; x.idle = cur_idle;
    x.led = led; x.gnt = g; x.rdy = r; x.busy = b;
    vecs.push_back(x);
  endtask

  // Scoreboard: each expectation is popped just after the edge that should produce it.
  always @(posedge aclk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if (led_output !== e.led || grant !== e.gnt || req_ready !== e.rdy || busy !== e.busy) begin
        n_bad++;
        $display("FAIL %s @%0t: got led=%h grant=%b ready=%b busy=%b, want led=%h grant=%b ready=%b busy=%b",
                 e.name, $time, led_output, grant, req_ready, busy, e.led, e.gnt, e.rdy, e.busy);
      end
    end
  end

  initial begin
    exp_t e;
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h3C; pat[3] = 8'h88;
    req_pattern = {8'h88, 8'h3C, 8'h22, 8'h11};

    // Reset held with every requester pending, then idle pass-through.
    cur = "reset";
    repeat (3) add(1, 4'hF, 8'h00, 4'h0, 4'h0, 0);
    cur = "idle_pass";
    repeat (2) add(0, 4'h0, 8'hA5, 4'h0, 4'h0, 0);

    // Single request from requester 2.
    cur = "single_req2";
    add(0, 4'b0100, 8'h3C, 4'b0100, 4'b0100, 1);
    repeat (3) add(0, 4'b0000, 8'h3C, 4'b0100, 4'b0000, 1);
    add(0, 4'b0000, 8'hA5, 4'h0, 4'h0, 0);

    // All four pending after reset: 0,1,2,3 back to back.
    cur = "all_rr";
    add(1, 4'h0, 8'h00, 4'h0, 4'h0, 0);
    for (int g = 0; g < 4; g++) begin
      add(0, 4'hF, pat[g], 4'(1 << g), 4'(1 << g), 1);
      repeat (3) add(0, 4'hF, pat[g], 4'(1 << g), 4'h0, 1);
    end
    add(0, 4'h0, 8'hA5, 4'h0, 4'h0, 0);

    // req0 re-raises at once; pending req1 goes first.
    cur = "rereq";
    add(0, 4'b0011, 8'h11, 4'b0001, 4'b0001, 1);
    repeat (3) add(0, 4'b0011, 8'h11, 4'b0001, 4'b0000, 1);
    add(0, 4'b0011, 8'h22, 4'b0010, 4'b0010, 1);
    repeat (3) add(0, 4'b0001, 8'h22, 4'b0010, 4'b0000, 1);
    add(0, 4'b0001, 8'h11, 4'b0001, 4'b0001, 1);
    repeat (3) add(0, 4'b0000, 8'h11, 4'b0001, 4'b0000, 1);
    add(0, 4'b0000, 8'hA5, 4'h0, 4'h0, 0);

    // Reset in req3's second SHOW cycle, then req0 beats req3.
    cur = "reset_mid";
    add(0, 4'b1000, 8'h88, 4'b1000, 4'b1000, 1);
    add(0, 4'b0000, 8'h88, 4'b1000, 4'b0000, 1);
    add(1, 4'b0000, 8'h00, 4'h0, 4'h0, 0);
    add(0, 4'b1001, 8'h11, 4'b0001, 4'b0001, 1);
    repeat (3) add(0, 4'b1000, 8'h11, 4'b0001, 4'b0000, 1);
    add(0, 4'b1000, 8'h88, 4'b1000, 4'b1000, 1);
    repeat (3) add(0, 4'b0000, 8'h88, 4'b1000, 4'b0000, 1);
    add(0, 4'b0000, 8'hA5, 4'h0, 4'h0, 0);

    // One-cycle req1 pulse during req0's SHOW is withdrawn.
    cur = "withdraw";
    add(0, 4'b0001, 8'h11, 4'b0001, 4'b0001, 1);
    add(0, 4'b0010, 8'h11, 4'b0001, 4'b0000, 1);
    repeat (2) add(0, 4'b0000, 8'h11, 4'b0001, 4'b0000, 1);
    repeat (2) add(0, 4'b0000, 8'hA5, 4'h0, 4'h0, 0);

    // Pattern change during SHOW is ignored.
    cur = "pat_change";
    add(0, 4'b0100, 8'h3C, 4'b0100, 4'b0100, 1);
    cur_p2 = 8'hFF;
    repeat (3) add(0, 4'b0000, 8'h3C, 4'b0100, 4'b0000, 1);
    add(0, 4'b0000, 8'hA5, 4'h0, 4'h0, 0);

    // idle_pattern follows with one cycle of latency.
    cur = "idle_change";
    cur_idle = 8'h5A;
    add(0, 4'h0, 8'h5A, 4'h0, 4'h0, 0);
    cur_idle = 8'hA5;
    add(0, 4'h0, 8'hA5, 4'h0, 4'h0, 0);

    // Finishing requester re-raises at lowest priority when hold ends with a new request.
    cur = "last_lowest";
    cur_p2 = 8'h3C;
    add(0, 4'b0100, 8'h3C, 4'b0100, 4'b0100, 1);
    repeat (2) add(0, 4'b0100, 8'h3C, 4'b0100, 4'b0000, 1);
    add(0, 4'b0110, 8'h3C, 4'b0100, 4'b0000, 1);
    add(0, 4'b0110, 8'h22, 4'b0010, 4'b0010, 1);
    repeat (3) add(0, 4'b0100, 8'h22, 4'b0010, 4'b0000, 1);
    add(0, 4'b0100, 8'h3C, 4'b0100, 4'b0100, 1);
    repeat (3) add(0, 4'b0000, 8'h3C, 4'b0100, 4'b0000, 1);
    add(0, 4'b0000, 8'hA5, 4'h0, 4'h0, 0);

    // Apply one row per cycle on the falling edge and queue its expectation.
    foreach (vecs[i]) begin
      @(negedge aclk);
      areset         = vecs[i].rst;
      req_valid      = vecs[i].vld;
      req_pattern[2] = vecs[i].p2;
      idle_pattern   = vecs[i].idle;
      e.name = vecs[i].name; e.led = vecs[i].led; e.gnt = vecs[i].gnt;
      e.rdy = vecs[i].rdy; e.busy = vecs[i].busy;
      sb.push_back(e);
    end

    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge aclk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations pending, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
